// File: rtl/adc_pkg.sv
// Shared types and sizing for the ADC averaging sequencer.
// Holds the sequencer state encoding and the default accumulator width.
package adc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } seq_state_e;

  localparam int DEF_RESOLUTION = 8;
  localparam int DEF_LOG2_AVG   = 2;
  localparam int ACC_W          = DEF_RESOLUTION + DEF_LOG2_AVG;

  // Half an LSB of the averaged result, or nothing when averaging is bypassed.
  function automatic int round_term(input int log2_avg);
    if (log2_avg == 0) begin
      return 0;
    end else begin
      return 1 << (log2_avg - 1);
    end
  endfunction

endpackage

// File: rtl/adc_period_timer.sv
// Loadable down-counter that saturates at zero.
// zero_o reports that the count will be zero once this cycle completes.
module adc_period_timer #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         zero_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: load wins over decrement, decrement stops at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != {W{1'b0}})) begin
      count_d = count_q - W'(1);
    end else begin
      count_d = count_q;
    end
  end

  assign zero_o = (count_d == {W{1'b0}});

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= {W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/adc_avg_sequencer.sv
// Periodic SAR ADC start sequencer with 2^LOG2_AVG sample averaging and a
// single-entry valid/ready output slot.
module adc_avg_sequencer
  import adc_pkg::*;
#(
  parameter int RESOLUTION = 8,
  parameter int LOG2_AVG   = 2,
  parameter int PERIOD_W   = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic [PERIOD_W-1:0]   period_i,
  output logic                  start_o,
  input  logic                  adc_rdy_i,
  input  logic [RESOLUTION-1:0] adc_result_i,
  output logic [RESOLUTION-1:0] avg_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  overrun_o,
  output logic                  busy_o
);

  localparam int ACC_WIDTH = RESOLUTION + LOG2_AVG;
  localparam int CNT_W     = LOG2_AVG + 1;
  localparam int N_AVG     = 1 << LOG2_AVG;
  localparam logic [ACC_WIDTH-1:0] ROUND    = ACC_WIDTH'(round_term(LOG2_AVG));
  localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(N_AVG - 1);

  seq_state_e            state_q, state_d;
  logic                  adc_rdy_q;
  logic                  conv_done_q, conv_done_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [RESOLUTION-1:0] avg_q, avg_d;
  logic                  valid_q, valid_d;
  logic                  overrun_q, overrun_d;
  logic                  start_q, start_d;
  logic                  busy_q, busy_d;

  logic                  rise_s;
  logic                  sample_s;
  logic                  group_done_s;
  logic                  slot_free_s;
  logic                  timer_zero_s;
  logic [PERIOD_W-1:0]   timer_load_val_s;
  logic [ACC_WIDTH-1:0]  sum_s;
  logic [ACC_WIDTH-1:0]  rounded_s;
  logic [RESOLUTION-1:0] avg_new_s;

  // Only the first ready edge of a WAIT counts as the conversion result.
  assign rise_s       = adc_rdy_i & ~adc_rdy_q;
  assign sample_s     = (state_q == WAIT) & rise_s & ~conv_done_q;
  assign group_done_s = sample_s & (cnt_q == LAST_CNT);
  assign slot_free_s  = ~valid_q | ready_i;

  assign sum_s     = acc_q + ACC_WIDTH'(adc_result_i);
  assign rounded_s = sum_s + ROUND;
  assign avg_new_s = RESOLUTION'(rounded_s >> LOG2_AVG);

  assign timer_load_val_s = (period_i == {PERIOD_W{1'b0}}) ? {PERIOD_W{1'b0}}
                                                           : period_i - PERIOD_W'(1);

  adc_period_timer #(
    .W (PERIOD_W)
  ) u_timer (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (state_q == START),
    .load_val_i (timer_load_val_s),
    .en_i       (state_q == WAIT),
    .zero_o     (timer_zero_s)
  );

  // Sequencer next state, conversion bookkeeping and accumulation.
  always_comb begin
    state_d     = state_q;
    conv_done_d = conv_done_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        acc_d       = {ACC_WIDTH{1'b0}};
        cnt_d       = {CNT_W{1'b0}};
        conv_done_d = 1'b0;
        if (en_i) begin
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        conv_done_d = 1'b0;
        state_d     = WAIT;
      end
      WAIT: begin
        if (sample_s) begin
          conv_done_d = 1'b1;
          if (group_done_s) begin
            acc_d = {ACC_WIDTH{1'b0}};
            cnt_d = {CNT_W{1'b0}};
          end else begin
            acc_d = sum_s;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          conv_done_d = conv_done_q;
        end
        // A result arriving in the expiry cycle still allows the exit.
        if ((conv_done_q | sample_s) & timer_zero_s) begin
          state_d = en_i ? START : IDLE;
        end else begin
          state_d = WAIT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output slot, sticky overrun and registered status outputs.
  always_comb begin
    avg_d     = avg_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (valid_q & ready_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
    if (group_done_s) begin
      if (slot_free_s) begin
        avg_d   = avg_new_s;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if ((state_q == IDLE) & en_i) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
    start_d = (state_d == START);
    busy_d  = (state_d != IDLE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      adc_rdy_q   <= 1'b0;
      conv_done_q <= 1'b0;
      acc_q       <= {ACC_WIDTH{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      avg_q       <= {RESOLUTION{1'b0}};
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      adc_rdy_q   <= adc_rdy_i;
      conv_done_q <= conv_done_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      avg_q       <= avg_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
    end
  end

  assign start_o   = start_q;
  assign busy_o    = busy_q;
  assign avg_o     = avg_q;
  assign valid_o   = valid_q;
  assign overrun_o = overrun_q;

endmodule

// File: tb/tb_adc_avg_sequencer.sv
// Self-checking bench: an N=4 and a pass-through instance share stimulus and
// an ADC model; a timestamp-based reference model is compared every cycle.
module tb_adc_avg_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        ready;
  logic [15:0] period;
  logic        adc_rdy;
  logic [7:0]  adc_res;

  logic       start0, valid0, ovr0, busy0;
  logic [7:0] avg0;
  logic       start1, valid1, ovr1, busy1;
  logic [7:0] avg1;

  always #5 clk = ~clk;

  adc_avg_sequencer #(.RESOLUTION(8), .LOG2_AVG(2), .PERIOD_W(16)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .period_i(period), .start_o(start0),
    .adc_rdy_i(adc_rdy), .adc_result_i(adc_res), .avg_o(avg0), .valid_o(valid0),
    .ready_i(ready), .overrun_o(ovr0), .busy_o(busy0));

  adc_avg_sequencer #(.RESOLUTION(8), .LOG2_AVG(0), .PERIOD_W(16)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .period_i(period), .start_o(start1),
    .adc_rdy_i(adc_rdy), .adc_result_i(adc_res), .avg_o(avg1), .valid_o(valid1),
    .ready_i(ready), .overrun_o(ovr1), .busy_o(busy1));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int ml(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  // ---------------- reference model (advances on each rising edge) -------
  int cyc = 0;
  bit m_busy, m_start, m_got, m_rdy_prev;
  int m_ts, m_per;
  int m_sum[2], m_n[2], m_avg[2];
  bit m_valid[2], m_ovr[2], m_free[2];

  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_busy = 0; m_start = 0; m_got = 0; m_rdy_prev = 0;
        for (int k = 0; k < 2; k++) begin
          m_sum[k] = 0; m_n[k] = 0; m_avg[k] = 0; m_valid[k] = 0; m_ovr[k] = 0;
        end
      end else begin
        bit rise;
        rise = adc_rdy && !m_rdy_prev;
        m_rdy_prev = adc_rdy;
        for (int k = 0; k < 2; k++) begin
          m_free[k] = !m_valid[k] || ready;
          if (m_valid[k] && ready) m_valid[k] = 0;
        end
        if (!m_busy) begin
          for (int k = 0; k < 2; k++) begin m_sum[k] = 0; m_n[k] = 0; end
          if (en) begin
            m_busy = 1; m_start = 1; m_ts = cyc + 1;
            m_ovr[0] = 0; m_ovr[1] = 0;
          end
        end else if (cyc == m_ts) begin
          m_start = 0;
          m_per = (period == 16'd0) ? 1 : int'(period);
          m_got = 0;
        end else begin
          if (rise && !m_got) begin
            m_got = 1;
            for (int k = 0; k < 2; k++) begin
              m_sum[k] += int'(adc_res);
              m_n[k]++;
              if (m_n[k] == (1 << ml(k))) begin
                if (m_free[k]) begin
                  m_avg[k] = (m_sum[k] + ((1 << ml(k)) >> 1)) >> ml(k);
                  m_valid[k] = 1;
                end else begin
                  m_ovr[k] = 1;
                end
                m_sum[k] = 0; m_n[k] = 0;
              end
            end
          end
          if (m_got && cyc >= m_ts + m_per - 1) begin
            if (en) begin m_start = 1; m_ts = cyc + 1; end
            else m_busy = 0;
          end
        end
      end
      cyc++;
    end
  end

  // ---------------- ADC core model: result 10 cycles after start ---------
  int adc_cnt = 0;
  int adc_rises = 0;
  int vals[$];

  initial begin
    adc_rdy = 1'b1;
    adc_res = 8'd0;
    forever begin
      @(posedge clk);
      #2;
      if (adc_cnt > 0) begin
        adc_cnt--;
        if (adc_cnt == 0) begin
          adc_rdy = 1'b1;
          adc_res = (vals.size() > 0) ? 8'(vals.pop_front()) : 8'h55;
          adc_rises++;
        end
      end
      if (start0 === 1'b1) begin
        adc_rdy = 1'b0;
        adc_cnt = 10;
      end
    end
  end

  // ---------------- per-cycle comparison against the model ----------------
  int start_cnt = 0, last_start = -1, last_gap = 0, vrise0 = 0;
  logic prev_valid0 = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (cyc >= 1) begin
        chk("start0", start0, m_start);
        chk("start1", start1, m_start);
        chk("busy0", busy0, m_busy);
        chk("busy1", busy1, m_busy);
        chk("valid0", valid0, m_valid[0]);
        chk("valid1", valid1, m_valid[1]);
        chk("overrun0", ovr0, m_ovr[0]);
        chk("overrun1", ovr1, m_ovr[1]);
        if (m_valid[0]) chk("avg0", avg0, m_avg[0]);
        if (m_valid[1]) chk("avg1", avg1, m_avg[1]);
        if (start0 === 1'b1) begin
          chk("start_during_conversion", m_rdy_prev, 1);
          if (last_start >= 0) last_gap = cyc - last_start;
          last_start = cyc;
          start_cnt++;
        end
        if (valid0 === 1'b1 && prev_valid0 !== 1'b1) vrise0++;
        prev_valid0 = valid0;
      end
    end
  end

  task automatic wait_for(input int sel, input int tgt, input int maxc, input string name);
    int n = 0;
    bit ok = 0;
    while (n < maxc && !ok) begin
      @(negedge clk);
      n++;
      case (sel)
        0: ok = (valid0 === 1'b1);
        1: ok = (valid1 === 1'b1);
        2: ok = (busy0 === 1'b0);
        3: ok = (ovr0 === 1'b1);
        4: ok = (start_cnt >= tgt);
        5: ok = (adc_rises >= tgt);
        default: ok = 1;
      endcase
    end
    chk({"wait_", name}, 32'(ok), 32'd1);
  endtask

  // ---------------- directed scenarios ------------------------------------
  initial begin
    int tgt, snap;
    rst_n = 1'b0; en = 1'b0; ready = 1'b1; period = 16'd20;
    repeat (3) @(negedge clk);
    chk("rst_start", start0, 0);
    chk("rst_valid", valid0, 0);
    chk("rst_avg", avg0, 0);
    chk("rst_overrun", ovr0, 0);
    chk("rst_busy", busy0, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic group, then a full-scale group.
    vals = '{10, 20, 30, 41, 255, 255, 255, 255};
    en = 1'b1;
    wait_for(1, 0, 40, "passthru_first");
    chk("passthru_avg", avg1, 10);
    chk("model_passthru", m_avg[1], 10);
    wait_for(0, 0, 120, "group_a");
    chk("avg_25", avg0, 25);
    chk("model_avg_25", m_avg[0], 25);
    chk("start_gap_20", last_gap, 20);
    @(negedge clk);
    chk("valid_one_cycle", valid0, 0);
    wait_for(0, 0, 120, "group_b");
    chk("avg_255", avg0, 255);
    chk("model_avg_255", m_avg[0], 255);
    en = 1'b0;
    wait_for(2, 0, 60, "idle_a");

    // Slot full through two groups.
    ready = 1'b0;
    vals = '{1, 2, 3, 4, 100, 100, 100, 101};
    en = 1'b1;
    wait_for(0, 0, 120, "group_c");
    chk("avg_3", avg0, 3);
    wait_for(3, 0, 120, "overrun_set");
    chk("avg_held", avg0, 3);
    chk("valid_held", valid0, 1);
    en = 1'b0;
    wait_for(2, 0, 60, "idle_c");
    ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("transfer_done", valid0, 0);
    chk("overrun_sticky", ovr0, 1);
    period = 16'd0;
    en = 1'b1;
    @(negedge clk);
    chk("overrun_cleared", ovr0, 0);
    chk("restart_pulse", start0, 1);

    // Short periods are stretched to the conversion time.
    tgt = start_cnt + 3;
    wait_for(4, tgt, 80, "starts_p0");
    chk("start_gap_p0", last_gap, 11);
    period = 16'd3;
    tgt = start_cnt + 3;
    wait_for(4, tgt, 80, "starts_p3");
    chk("start_gap_p3", last_gap, 11);
    en = 1'b0;
    wait_for(2, 0, 60, "idle_p");

    // Enable dropped mid-group: partial group discarded.
    period = 16'd20;
    vals = '{7, 7, 40, 50, 60, 70};
    snap = vrise0;
    en = 1'b1;
    tgt = adc_rises + 2;
    wait_for(5, tgt, 80, "two_samples");
    en = 1'b0;
    wait_for(2, 0, 60, "idle_drop");
    chk("no_partial_avg", vrise0, snap);
    en = 1'b1;
    wait_for(0, 0, 150, "group_fresh");
    chk("avg_55", avg0, 55);
    en = 1'b0;
    wait_for(2, 0, 60, "idle_d");

    // Synchronous reset in the middle of a WAIT.
    vals = '{9, 8, 12, 16, 20};
    en = 1'b1;
    tgt = start_cnt + 1;
    wait_for(4, tgt, 20, "start_r");
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    en = 1'b0;
    snap = adc_rises;
    @(negedge clk);
    chk("mid_rst_start", start0, 0);
    chk("mid_rst_busy", busy0, 0);
    chk("mid_rst_valid", valid0, 0);
    chk("mid_rst_avg", avg0, 0);
    chk("mid_rst_avg1", avg1, 0);
    chk("mid_rst_overrun", ovr0, 0);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("late_edge_seen", adc_rises, snap + 1);
    chk("late_edge_busy", busy0, 0);
    chk("late_edge_valid", valid0, 0);
    en = 1'b1;
    wait_for(0, 0, 150, "group_after_rst");
    chk("avg_14", avg0, 14);
    en = 1'b0;
    wait_for(2, 0, 60, "idle_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
